mem_unit: RTL and testbench

MEM_UNIT -- requirements
Module: mem_unit

---
 rtl/mem_unit.sv | 187 ++++++++++++++++++
 tb/tb_mem_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_unit.sv
// mem_unit: byte-wide RAM sequencer for 8/16-bit loads and stores.
// A request is accepted in IDLE. Reads and writes of a word are split into
// two byte accesses in little-endian order: the low byte is at A and the high
// byte at A+1, where A+1 wraps at 2^ADDR_WIDTH.
// Ports:
//   I_clk, I_reset (async, active-low)
//   I_enable, I_memory_mode[1:0], I_memory_size[1:0], I_addr, I_data[15:0] : request
//   O_ram_en, O_ram_we, O_ram_addr, O_ram_wdata[7:0], I_ram_rdata[7:0]   : sync RAM
//   O_data[15:0], O_busy, O_done, O_err                                  : status/result
module mem_unit #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  I_clk,
  input  logic                  I_reset,
  input  logic                  I_enable,
  input  logic [1:0]            I_memory_mode,
  input  logic [1:0]            I_memory_size,
  input  logic [ADDR_WIDTH-1:0] I_addr,
  input  logic [15:0]           I_data,
  output logic                  O_ram_en,
  output logic                  O_ram_we,
  output logic [ADDR_WIDTH-1:0] O_ram_addr,
  output logic [7:0]            O_ram_wdata,
  input  logic [7:0]            I_ram_rdata,
  output logic [15:0]           O_data,
  output logic                  O_busy,
  output logic                  O_done,
  output logic                  O_err
);

  localparam logic [1:0] MEM_NOP   = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;
  localparam logic [1:0] SIZE_BYTE = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_WR0,
    S_WR1,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_wdata_hi;
  logic                  r_word;
  logic                  r_ram_en;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [7:0]            r_ram_wdata;
  logic [15:0]           r_rdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_size_ok;
  logic                  w_is_rd;
  logic                  w_is_wr;
  logic                  w_is_nop;
  logic [ADDR_WIDTH-1:0] w_addr_inc;

  // Request decode: only legal reads/writes touch the RAM.
  assign w_size_ok  = (I_memory_size == SIZE_BYTE) || (I_memory_size == SIZE_WORD);
  assign w_is_rd    = (I_memory_mode == MEM_READ)  && w_size_ok;
  assign w_is_wr    = (I_memory_mode == MEM_WRITE) && w_size_ok;
  assign w_is_nop   = (I_memory_mode == MEM_NOP);
  assign w_addr_inc = r_addr + ADDR_ONE;

  // Sequencer with all outputs registered alongside the state.
  always_ff @(posedge I_clk or negedge I_reset) begin
    if (!I_reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata_hi  <= '0;
      r_word      <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          if (I_enable) begin
            r_addr     <= I_addr;
            r_wdata_hi <= I_data[15:8];
            r_word     <= (I_memory_size == SIZE_WORD);
            r_busy     <= 1'b1;
            if (w_is_rd) begin
              r_state    <= S_RD0;
              r_ram_en   <= 1'b1;
              r_ram_addr <= I_addr;
            end else if (w_is_wr) begin
              r_state     <= S_WR0;
              r_ram_en    <= 1'b1;
              r_ram_we    <= 1'b1;
              r_ram_addr  <= I_addr;
              r_ram_wdata <= I_data[7:0];
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= !w_is_nop;
            end
          end
        end
        S_RD0: begin
          r_state <= S_RD1;
          // High-byte fetch overlaps the low-byte return.
          if (r_word) begin
            r_ram_en   <= 1'b1;
            r_ram_addr <= w_addr_inc;
          end else begin
            r_ram_en <= 1'b0;
          end
        end
        S_RD1: begin
          r_ram_en      <= 1'b0;
          r_rdata[7:0]  <= I_ram_rdata;
          if (r_word) begin
            r_state <= S_RD2;
          end else begin
            r_rdata[15:8] <= 8'h00;
            r_state       <= S_DONE;
            r_done        <= 1'b1;
          end
        end
        S_RD2: begin
          r_rdata[15:8] <= I_ram_rdata;
          r_state       <= S_DONE;
          r_done        <= 1'b1;
        end
        S_WR0: begin
          if (r_word) begin
            r_state     <= S_WR1;
            r_ram_en    <= 1'b1;
            r_ram_we    <= 1'b1;
            r_ram_addr  <= w_addr_inc;
            r_ram_wdata <= r_wdata_hi;
          end else begin
            r_state  <= S_DONE;
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        S_WR1: begin
          r_state  <= S_DONE;
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          r_done   <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign O_ram_en    = r_ram_en;
  assign O_ram_we    = r_ram_we;
  assign O_ram_addr  = r_ram_addr;
  assign O_ram_wdata = r_ram_wdata;
  assign O_data      = r_rdata;
  assign O_busy      = r_busy;
  assign O_done      = r_done;
  assign O_err       = r_err;

endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: scoreboard bench for mem_unit. The driver predicts every RAM
// strobe and every completion (cycle, err, data) from a byte-array model and
// queues them; the monitor pops and compares whenever the DUT presents one.
module tb_mem_unit;

  logic        I_clk = 1'b0;
  logic        I_reset = 1'b1;
  logic        I_enable = 1'b0;
  logic [1:0]  I_memory_mode = 2'b00;
  logic [1:0]  I_memory_size = 2'b00;
  logic [15:0] I_addr = 16'h0000;
  logic [15:0] I_data = 16'h0000;
  logic [7:0]  I_ram_rdata = 8'h00;
  logic        O_ram_en;
  logic        O_ram_we;
  logic [15:0] O_ram_addr;
  logic [7:0]  O_ram_wdata;
  logic [15:0] O_data;
  logic        O_busy;
  logic        O_done;
  logic        O_err;

  mem_unit #(.ADDR_WIDTH(16)) dut (
    .I_clk        (I_clk),
    .I_reset      (I_reset),
    .I_enable     (I_enable),
    .I_memory_mode(I_memory_mode),
    .I_memory_size(I_memory_size),
    .I_addr       (I_addr),
    .I_data       (I_data),
    .O_ram_en     (O_ram_en),
    .O_ram_we     (O_ram_we),
    .O_ram_addr   (O_ram_addr),
    .O_ram_wdata  (O_ram_wdata),
    .I_ram_rdata  (I_ram_rdata),
    .O_data       (O_data),
    .O_busy       (O_busy),
    .O_done       (O_done),
    .O_err        (O_err)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    int          cyc;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } ram_exp_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [15:0] data;
  } done_exp_t;

  ram_exp_t    ram_q[$];
  done_exp_t   done_q[$];
  ram_exp_t    mon_re;
  done_exp_t   mon_de;
  logic [7:0]  ram       [0:65535];
  logic [7:0]  model_mem [0:65535];
  logic [15:0] last_rd = 16'h0000;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge I_clk) cyc <= cyc + 1;

  // Synchronous byte RAM seen by the DUT.
  always @(posedge I_clk) begin
    if (O_ram_en) begin
      if (O_ram_we) ram[O_ram_addr] <= O_ram_wdata;
      else          I_ram_rdata     <= ram[O_ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares RAM strobes and completions against queued predictions.
  always @(negedge I_clk) begin
    if (I_reset) begin
      if (O_ram_en) begin
        if (ram_q.size() == 0) begin
          chk("unexpected_ram_access", {16'h0, O_ram_addr}, 32'hFFFF_FFFF);
        end else begin
          mon_re = ram_q.pop_front();
          chk("ram_cycle", cyc, mon_re.cyc);
          chk("ram_we", {31'h0, O_ram_we}, {31'h0, mon_re.we});
          chk("ram_addr", {16'h0, O_ram_addr}, {16'h0, mon_re.addr});
          if (mon_re.we) chk("ram_wdata", {24'h0, O_ram_wdata}, {24'h0, mon_re.wdata});
        end
      end else begin
        chk("ram_we_idle", {31'h0, O_ram_we}, 32'h0);
      end
      if (O_done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", {31'h0, O_done}, 32'h0);
        end else begin
          mon_de = done_q.pop_front();
          chk("done_cycle", cyc, mon_de.cyc);
          chk("done_err", {31'h0, O_err}, {31'h0, mon_de.err});
          chk("done_data", {16'h0, O_data}, {16'h0, mon_de.data});
          chk("done_busy", {31'h0, O_busy}, 32'h1);
        end
      end else begin
        chk("err_without_done", {31'h0, O_err}, 32'h0);
      end
    end
  end

  task automatic push_ram(input int c, input logic we, input logic [15:0] a, input logic [7:0] wd);
    ram_exp_t e;
    e.cyc = c; e.we = we; e.addr = a; e.wdata = wd;
    ram_q.push_back(e);
  endtask

  // Called at a negedge; returns at the first negedge with the DUT idle.
  task automatic wait_idle();
    int n = 0;
    while (O_busy && n < 30) begin
      @(negedge I_clk);
      n++;
    end
    chk("idle_wait", {31'h0, O_busy}, 32'h0);
  endtask

  // Predicts the whole transaction, then strobes I_enable for one edge.
  task automatic issue(input logic [1:0] m, input logic [1:0] s,
                       input logic [15:0] a, input logic [15:0] d);
    int          acc;
    int          lat;
    logic        size_ok;
    logic        word;
    logic [15:0] a1;
    done_exp_t   de;
    wait_idle();
    acc     = cyc + 1;
    a1      = a + 16'd1;
    size_ok = (s == 2'd1) || (s == 2'd2);
    word    = (s == 2'd2);
    if (m == 2'b01 && size_ok) begin
      push_ram(acc, 1'b0, a, 8'h00);
      if (word) push_ram(acc + 1, 1'b0, a1, 8'h00);
      last_rd = word ? {model_mem[a1], model_mem[a]} : {8'h00, model_mem[a]};
      lat = word ? 4 : 3;
    end else if (m == 2'b10 && size_ok) begin
      push_ram(acc, 1'b1, a, d[7:0]);
      model_mem[a] = d[7:0];
      if (word) begin
        push_ram(acc + 1, 1'b1, a1, d[15:8]);
        model_mem[a1] = d[15:8];
      end
      lat = word ? 3 : 2;
    end else begin
      lat = 1;
    end
    de.cyc  = acc + lat - 1;
    de.err  = (m == 2'b11) || (m != 2'b00 && !size_ok);
    de.data = last_rd;
    done_q.push_back(de);
    I_memory_mode = m;
    I_memory_size = s;
    I_addr        = a;
    I_data        = d;
    I_enable      = 1'b1;
    @(posedge I_clk);
    @(negedge I_clk);
    I_enable      = 1'b0;
    // Later input changes must not disturb the access in flight.
    I_memory_mode = 2'($urandom);
    I_memory_size = 2'($urandom);
    I_addr        = 16'($urandom);
    I_data        = 16'($urandom);
  endtask

  function automatic logic [15:0] rand_addr();
    int sel = $urandom_range(0, 9);
    if (sel < 5)      return 16'h0100 + 16'($urandom_range(0, 31));
    else if (sel < 7) return 16'hFFF0 + 16'($urandom_range(0, 15));
    else              return 16'($urandom);
  endfunction

  initial begin
    int          acc;
    logic [1:0]  m;
    logic [1:0]  s;
    logic [7:0]  v;

    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      ram[i]       = v;
      model_mem[i] = v;
    end

    // Reset values, applied asynchronously before any clock edge.
    #1 I_reset = 1'b0;
    #1;
    chk("rst_ram_en", {31'h0, O_ram_en}, 32'h0);
    chk("rst_ram_we", {31'h0, O_ram_we}, 32'h0);
    chk("rst_ram_addr", {16'h0, O_ram_addr}, 32'h0);
    chk("rst_ram_wdata", {24'h0, O_ram_wdata}, 32'h0);
    chk("rst_data", {16'h0, O_data}, 32'h0);
    chk("rst_busy", {31'h0, O_busy}, 32'h0);
    chk("rst_done", {31'h0, O_done}, 32'h0);
    chk("rst_err", {31'h0, O_err}, 32'h0);
    repeat (2) @(negedge I_clk);
    I_reset = 1'b1;
    @(negedge I_clk);

    // Directed cases.
    issue(2'b10, 2'd2, 16'h1234, 16'hBEEF);
    issue(2'b01, 2'd2, 16'h1234, 16'h0000);
    issue(2'b10, 2'd1, 16'h0010, 16'h3380);
    issue(2'b01, 2'd1, 16'h0010, 16'h0000);
    issue(2'b10, 2'd2, 16'hFFFF, 16'hA55A);
    issue(2'b01, 2'd2, 16'hFFFF, 16'h0000);
    issue(2'b01, 2'd3, 16'h0020, 16'h0000);
    issue(2'b11, 2'd1, 16'h0020, 16'h0000);
    issue(2'b10, 2'd0, 16'h0020, 16'h1111);
    issue(2'b00, 2'd2, 16'h0020, 16'h2222);

    // Enable held high through a busy word read must be dropped.
    issue(2'b01, 2'd2, 16'h1234, 16'h0000);
    I_memory_mode = 2'b10;
    I_memory_size = 2'd2;
    I_addr        = 16'h5555;
    I_data        = 16'hDEAD;
    I_enable      = 1'b1;
    repeat (3) @(negedge I_clk);
    I_enable = 1'b0;
    issue(2'b01, 2'd2, 16'h5555, 16'h0000);

    // Reset during WR0 of a word write: no WR1, no done.
    wait_idle();
    acc = cyc + 1;
    push_ram(acc, 1'b1, 16'h2000, 8'h11);
    I_memory_mode = 2'b10;
    I_memory_size = 2'd2;
    I_addr        = 16'h2000;
    I_data        = 16'h2211;
    I_enable      = 1'b1;
    @(posedge I_clk);
    @(negedge I_clk);
    I_enable = 1'b0;
    #2 I_reset = 1'b0;
    #1;
    chk("mid_rst_ram_en", {31'h0, O_ram_en}, 32'h0);
    chk("mid_rst_ram_we", {31'h0, O_ram_we}, 32'h0);
    chk("mid_rst_ram_addr", {16'h0, O_ram_addr}, 32'h0);
    chk("mid_rst_ram_wdata", {24'h0, O_ram_wdata}, 32'h0);
    chk("mid_rst_busy", {31'h0, O_busy}, 32'h0);
    chk("mid_rst_data", {16'h0, O_data}, 32'h0);
    last_rd = 16'h0000;
    repeat (2) @(negedge I_clk);
    I_reset = 1'b1;
    repeat (3) @(negedge I_clk);
    chk("abort_ram_q_empty", ram_q.size(), 32'h0);
    chk("abort_done_q_empty", done_q.size(), 32'h0);
    issue(2'b10, 2'd1, 16'h2000, 16'h0077);
    issue(2'b01, 2'd2, 16'h2000, 16'h0000);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge I_clk);
      case ($urandom_range(0, 9))
        0:       m = 2'b00;
        1:       m = 2'b11;
        2, 3, 4, 5: m = 2'b01;
        default: m = 2'b10;
      endcase
      if (m == 2'b00)              s = 2'd1 + 2'($urandom_range(0, 1));
      else if ($urandom_range(0, 9) == 0) s = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
      else                         s = 2'd1 + 2'($urandom_range(0, 1));
      issue(m, s, rand_addr(), 16'($urandom));
    end

    wait_idle();
    repeat (3) @(negedge I_clk);
    chk("final_ram_q_empty", ram_q.size(), 32'h0);
    chk("final_done_q_empty", done_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
